equiv_sweep_checker: RTL
========================

Name: equiv_sweep_checker

Overview:
- Synthesisable exhaustive-stimulus generator and equivalence checker. It is the parametrised successor to the hand-written 4-input truth-table sweep used for the equivalence-check exercises.
- Drives one shared N-bit vector into two circuits under comparison and sweeps all 2^IN_W combinations in ascending order.
- Compares the two outputs under a bit mask, counts mismatches and records the first failing vector. Usable in simulation benches and on-board self-test.

Parameters:
IN_W, 4, stimulus width; the sweep covers 0 .. 2^IN_W-1 (range 1..16)
OUT_W, 2, width of each compared output bus
DUT_LAT, 0, cycles from stim change to valid DUT output (range 0..7)
STOP_ON_FAIL, 0, 1 = abort the sweep at the first mismatch; 0 = full sweep

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a sweep; honoured only in IDLE or DONE
cmp_mask  in  OUT_W  1 = compare this bit; sampled at start, held during the sweep
out_a  in  OUT_W  output of circuit A
out_b  in  OUT_W  output of circuit B
stim  out  IN_W  vector driven to both circuits
busy  out  1  high in SWEEP and DRAIN
done  out  1  high in DONE
pass  out  1  valid when done; 1 iff mismatch_count==0
mismatch_count  out  IN_W+1  number of failing vectors, saturating
first_fail_vec  out  IN_W  first vector that mismatched
first_fail_valid  out  1  first_fail_vec holds a real capture

Behaviour:
- Reset (synchronous, active-high): state=IDLE; stim=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail_vec=0, first_fail_valid=0; tag pipeline cleared.
- A reset asserted mid-sweep aborts immediately. No partial results are retained.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE + start:
  - next cycle enters SWEEP with stim=0;
  - mismatch_count, first_fail_*, pass and done are cleared;
  - the masked register is latched from cmp_mask.
- SWEEP:
  - stim increments by 1 each cycle;
  - a tag {valid, vector} enters a DUT_LAT-deep shift pipeline each cycle.
- Compare point: when the tag emerges, evaluate ((out_a ^ out_b) & mask) != 0.
  - With DUT_LAT=0 the comparison is made in the same cycle stim is presented.
  - On mismatch: mismatch_count increments, saturating at all-ones.
  - If first_fail_valid=0, capture first_fail_vec=tag vector and set first_fail_valid=1.
- Leaving SWEEP:
  - The cycle stim = 2^IN_W-1 is issued, the next state is DRAIN. stim holds its last value; no wrap to 0.
  - STOP_ON_FAIL=1: a detected mismatch stops issue immediately and goes to DRAIN. Vectors already in flight are still compared and counted.
- DRAIN: lasts exactly DUT_LAT cycles, then DONE. DRAIN is skipped when DUT_LAT=0.
- DONE:
  - done=1, pass=(mismatch_count==0); all results held;
  - busy=0;
  - stim holds its last value until the next start.
- start while busy is ignored. start coincident with rst: reset wins.
- Total run time (full sweep, start pulse to done): 2^IN_W + DUT_LAT + 1 cycles.
- mismatch_count width IN_W+1 holds 2^IN_W exactly. Saturation applies only as a guard.

Decomposition:
- Package equiv_pkg holds:
  - the state enum (IDLE, SWEEP, DRAIN, DONE);
  - a function returning last vector = 2^IN_W-1;
  - the localparam CNT_W = IN_W+1.
- One sub-module, lat_tag_pipe: a parametrised shift register of {valid, IN_W} tags with depth DUT_LAT. It degenerates to a wire at depth 0.

Test Plan:
- IN_W=4, DUT_LAT=0; out_a = out_b = same 4-input function; start -> stim 0..15 in 16 cycles, done after 17, pass=1, count=0, first_fail_valid=0.
- IN_W=4; out_b differs only at vectors 5 and 12; STOP_ON_FAIL=0 -> count=2, first_fail_vec=5, pass=0, stim ends at 15.
- Same as above with STOP_ON_FAIL=1, DUT_LAT=2 -> issue stops after the mismatch at 5. Vectors 6 and 7 are still compared, final count=1, first_fail_vec=5.
- cmp_mask=2'b01 with the difference only in bit 1 at every vector -> pass=1, count=0. cmp_mask=2'b11 -> count=16.
- rst asserted at stim=9 mid-sweep -> next cycle all outputs at reset values, state IDLE. A new start then gives a clean full run.
- start pulsed while busy -> ignored, stim sequence uninterrupted. start in DONE -> results cleared and the sweep restarts from 0.

Source files
------------

// File: rtl/equiv_pkg.sv
// Shared types and helpers for the exhaustive-sweep equivalence checker.
// Sweep state encoding, last-vector and counter-width helpers.
package equiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Final vector of a sweep: 2^in_w - 1 (in_w is 1..16).
  function automatic logic [15:0] last_vec(input int in_w);
    return 16'((32'd1 << in_w) - 32'd1);
  endfunction

  // Mismatch counter width: one extra bit so 2^in_w failures fit exactly.
  function automatic int cnt_width(input int in_w);
    return in_w + 32'sd1;
  endfunction

endpackage

// File: rtl/equiv_sweep_checker_lat_tag_pipe.sv
// Shift register of {valid, vector} tags that tracks each issued vector
// through the latency of the circuits under comparison; a wire at depth 0.
module lat_tag_pipe #(
  parameter int IN_W  = 4,
  parameter int DEPTH = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_vec,
  output logic            out_valid,
  output logic [IN_W-1:0] out_vec
);

  localparam int SLOTS = (DEPTH == 0) ? 1 : DEPTH;

  logic [SLOTS-1:0] valid_r;
  logic [IN_W-1:0]  vec_r [SLOTS];

  // Shift tags one slot per cycle; reset flushes every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        vec_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      vec_r[0]   <= in_vec;
      for (int i = 1; i < SLOTS; i++) begin
        valid_r[i] <= valid_r[i-1];
        vec_r[i]   <= vec_r[i-1];
      end
    end
  end

  assign out_valid = (DEPTH == 0) ? in_valid : valid_r[SLOTS-1];
  assign out_vec   = (DEPTH == 0) ? in_vec   : vec_r[SLOTS-1];

endmodule

// File: rtl/equiv_sweep_checker.sv
// Exhaustive-stimulus generator and equivalence checker: sweeps all input
// vectors into two circuits and counts masked output mismatches.
module equiv_sweep_checker
  import equiv_pkg::*;
#(
  parameter int IN_W         = 4,
  parameter int OUT_W        = 2,
  parameter int DUT_LAT      = 0,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OUT_W-1:0]    cmp_mask,
  input  logic [OUT_W-1:0]    out_a,
  input  logic [OUT_W-1:0]    out_b,
  output logic [IN_W-1:0]     stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [IN_W:0]       mismatch_count,
  output logic [IN_W-1:0]     first_fail_vec,
  output logic                first_fail_valid
);

  localparam int              CNT_W      = cnt_width(IN_W);
  localparam logic [IN_W-1:0] LAST_VEC   = IN_W'(last_vec(IN_W));
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam bit              NO_DRAIN   = (DUT_LAT == 0);
  localparam logic [2:0]      DRAIN_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  state_e           state_r;
  logic [IN_W-1:0]  stim_r;
  logic [OUT_W-1:0] mask_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IN_W-1:0]  ff_vec_r;
  logic             ff_valid_r;
  logic [2:0]       drain_cnt_r;

  logic             sweep_s;
  logic             tag_valid_s;
  logic [IN_W-1:0]  tag_vec_s;
  logic             mismatch_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [IN_W-1:0]  ff_vec_nxt_s;
  logic             ff_valid_nxt_s;
  logic             issue_end_s;

  assign sweep_s = (state_r == SWEEP);

  lat_tag_pipe #(
    .IN_W  (IN_W),
    .DEPTH (DUT_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (sweep_s),
    .in_vec    (stim_r),
    .out_valid (tag_valid_s),
    .out_vec   (tag_vec_s)
  );

  // Compare point: judge the tag emerging now and prepare result updates.
  always_comb begin
    mismatch_s     = 1'b0;
    cnt_nxt_s      = cnt_r;
    ff_vec_nxt_s   = ff_vec_r;
    ff_valid_nxt_s = ff_valid_r;
    if (tag_valid_s && (((out_a ^ out_b) & mask_r) != {OUT_W{1'b0}})) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
    if (mismatch_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
    if (mismatch_s && !ff_valid_r) begin
      ff_vec_nxt_s   = tag_vec_s;
      ff_valid_nxt_s = 1'b1;
    end else begin
      ff_vec_nxt_s   = ff_vec_r;
      ff_valid_nxt_s = ff_valid_r;
    end
    issue_end_s = (stim_r == LAST_VEC) || (STOP_ON_FAIL && mismatch_s);
  end

  // Sweep controller; result registers follow the compare point every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      stim_r      <= '0;
      mask_r      <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      cnt_r       <= '0;
      ff_vec_r    <= '0;
      ff_valid_r  <= 1'b0;
      drain_cnt_r <= 3'd0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      ff_vec_r   <= ff_vec_nxt_s;
      ff_valid_r <= ff_valid_nxt_s;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r    <= SWEEP;
            stim_r     <= '0;
            mask_r     <= cmp_mask;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            cnt_r      <= '0;
            ff_vec_r   <= '0;
            ff_valid_r <= 1'b0;
          end
        end
        SWEEP: begin
          if (issue_end_s) begin
            if (NO_DRAIN) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (cnt_nxt_s == '0);
            end else begin
              state_r     <= DRAIN;
              drain_cnt_r <= 3'd0;
            end
          end else begin
            stim_r <= stim_r + IN_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (cnt_nxt_s == '0);
          end else begin
            drain_cnt_r <= drain_cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign stim             = stim_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign mismatch_count   = cnt_r;
  assign first_fail_vec   = ff_vec_r;
  assign first_fail_valid = ff_valid_r;

endmodule
